mux_2x1: RTL and testbench

Registered, width-parameterised 2:1 multiplexer used as the basic selection cell of the barrel-shifter datapath. Each stage of the shifter instantiates a bank of these cells: one `sel` bit per stage picks between the unshifted word (`in0`) and the shifted word (`in1`). The output is registered so that stages can be pipelined. A qualifying valid bit travels alongside the data.

---
 rtl/mux_pkg.sv | 15 +
 rtl/mux_cell.sv | 19 +
 rtl/mux_2x1.sv | 65 ++++++
 tb/tb_mux_2x1.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared definitions for the registered 2:1 selection cell used by the barrel shifter.
package mux_pkg;

    localparam int unsigned MUX_MAX_WIDTH = 64;

    typedef enum logic {
        SEL_IN0 = 1'b0,
        SEL_IN1 = 1'b1
    } mux_sel_e;

    function automatic bit mux_width_ok(input int unsigned w);
        return (w >= 1) && (w <= MUX_MAX_WIDTH);
    endfunction

endpackage

// File: rtl/mux_cell.sv
// One-bit combinational 2:1 select, replicated per bit by mux_2x1 and reusable by the shifter.
module mux_cell
    import mux_pkg::*;
(
    input  logic in0,
    input  logic in1,
    input  logic sel,
    output logic y
);

    // Only an explicit 1 picks in1, so an unknown select falls back to in0.
    always_comb begin
        y = in0;
        if (sel == SEL_IN1) begin
            y = in1;
        end
    end

endmodule

// File: rtl/mux_2x1.sv
// Width-parameterised 2:1 multiplexer with optional output register and a travelling valid bit.
module mux_2x1
    import mux_pkg::*;
#(
    parameter int unsigned WIDTH   = 1,
    parameter bit          REG_OUT = 1'b1
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic             sel,
    input  logic             in_valid,
    output logic [WIDTH-1:0] m_out,
    output logic             out_valid,
    output logic [WIDTH-1:0] m_comb
);

    if (!mux_width_ok(WIDTH)) begin : g_width_err
        $error("mux_2x1: WIDTH %0d outside 1..%0d", WIDTH, MUX_MAX_WIDTH);
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        mux_cell u_cell (
            .in0 (in0[i]),
            .in1 (in1[i]),
            .sel (sel),
            .y   (m_comb[i])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
        end
    end

    if (REG_OUT) begin : g_reg_out
        logic [WIDTH-1:0] m_reg;

        // Holding on in_valid=0 keeps the last selection visible to the next stage.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                m_reg <= '0;
            end else if (in_valid) begin
                m_reg <= m_comb;
            end
        end

        assign m_out = m_reg;

        a_hold_stable : assert property (@(posedge clk)
            (rst_n && !in_valid) |=> $stable(m_out))
            else $error("mux_2x1: m_out changed while no valid data was loaded");
    end else begin : g_comb_out
        assign m_out = m_comb;
    end

    a_reset_clears_valid : assert property (@(posedge clk)
        !rst_n |=> !out_valid)
        else $error("mux_2x1: out_valid set in the cycle after reset");

endmodule

// File: tb/tb_mux_2x1.sv
// Self-checking bench for mux_2x1: directed scenarios on three configurations plus a randomized run.
module tb_mux_2x1;

    logic clk;
    int   tests_run;
    int   tests_failed;

    // WIDTH=1, registered
    logic       rst_n_a, in0_a, in1_a, sel_a, in_valid_a;
    logic       m_out_a, out_valid_a, m_comb_a;
    // WIDTH=8, registered
    logic       rst_n_b, sel_b, in_valid_b, out_valid_b;
    logic [7:0] in0_b, in1_b, m_out_b, m_comb_b;
    // WIDTH=4, combinational output
    logic       rst_n_c, sel_c, in_valid_c, out_valid_c;
    logic [3:0] in0_c, in1_c, m_out_c, m_comb_c;

    mux_2x1 #(.WIDTH(1), .REG_OUT(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n_a), .in0(in0_a), .in1(in1_a), .sel(sel_a),
        .in_valid(in_valid_a), .m_out(m_out_a), .out_valid(out_valid_a), .m_comb(m_comb_a)
    );

    mux_2x1 #(.WIDTH(8), .REG_OUT(1'b1)) dut_b (
        .clk(clk), .rst_n(rst_n_b), .in0(in0_b), .in1(in1_b), .sel(sel_b),
        .in_valid(in_valid_b), .m_out(m_out_b), .out_valid(out_valid_b), .m_comb(m_comb_b)
    );

    mux_2x1 #(.WIDTH(4), .REG_OUT(1'b0)) dut_c (
        .clk(clk), .rst_n(rst_n_c), .in0(in0_c), .in1(in1_c), .sel(sel_c),
        .in_valid(in_valid_c), .m_out(m_out_c), .out_valid(out_valid_c), .m_comb(m_comb_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n_a = 1'b0; in0_a = 1'b0; in1_a = 1'b1; sel_a = 1'b1; in_valid_a = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            tests_run += 3;
            if (m_out_a !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL reset_m_out cycle %0d: got %b expected 0", c, m_out_a);
            end
            if (out_valid_a !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL reset_out_valid cycle %0d: got %b expected 0", c, out_valid_a);
            end
            if (m_comb_a !== 1'b1) begin
                tests_failed++;
                $display("[TB] FAIL reset_m_comb cycle %0d: got %b expected 1", c, m_comb_a);
            end
        end
    endtask

    task automatic test_basic_select();
        rst_n_a = 1'b1; in0_a = 1'b0; in1_a = 1'b1; sel_a = 1'b1; in_valid_a = 1'b1;
        tick();
        tests_run += 2;
        if (m_out_a !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL select_in1: got %b expected 1", m_out_a);
        end
        if (out_valid_a !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL select_valid: got %b expected 1", out_valid_a);
        end
        sel_a = 1'b0;
        tick();
        tests_run++;
        if (m_out_a !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL select_in0: got %b expected 0", m_out_a);
        end
    endtask

    task automatic test_hold();
        sel_a = 1'b1; in_valid_a = 1'b1;
        tick();
        sel_a = 1'b0; in_valid_a = 1'b0;
        for (int c = 0; c < 2; c++) begin
            tick();
            tests_run += 2;
            if (m_out_a !== 1'b1) begin
                tests_failed++;
                $display("[TB] FAIL hold_m_out cycle %0d: got %b expected 1", c, m_out_a);
            end
            if (out_valid_a !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL hold_valid cycle %0d: got %b expected 0", c, out_valid_a);
            end
        end
    endtask

    task automatic test_wide();
        logic       sel_seq [3] = '{1'b0, 1'b1, 1'b0};
        logic [7:0] exp_seq [3] = '{8'hA5, 8'h3C, 8'hA5};
        rst_n_b = 1'b0; in_valid_b = 1'b0;
        tick();
        rst_n_b = 1'b1; in0_b = 8'hA5; in1_b = 8'h3C; in_valid_b = 1'b1;
        for (int c = 0; c < 3; c++) begin
            sel_b = sel_seq[c];
            tick();
            tests_run += 2;
            if (m_out_b !== exp_seq[c]) begin
                tests_failed++;
                $display("[TB] FAIL wide_m_out step %0d: got %h expected %h", c, m_out_b, exp_seq[c]);
            end
            if (out_valid_b !== 1'b1) begin
                tests_failed++;
                $display("[TB] FAIL wide_valid step %0d: got %b expected 1", c, out_valid_b);
            end
        end
    endtask

    task automatic test_mid_reset();
        rst_n_b = 1'b1; sel_b = 1'b1; in1_b = 8'hFF; in0_b = 8'h00; in_valid_b = 1'b1;
        tick();
        tick();
        tests_run++;
        if (m_out_b !== 8'hFF) begin
            tests_failed++;
            $display("[TB] FAIL midrst_stream: got %h expected ff", m_out_b);
        end
        rst_n_b = 1'b0;
        tick();
        tests_run += 2;
        if (m_out_b !== 8'h00 || out_valid_b !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL midrst_cleared: got m_out=%h valid=%b expected 00/0", m_out_b, out_valid_b);
        end
        if (m_comb_b !== 8'hFF) begin
            tests_failed++;
            $display("[TB] FAIL midrst_m_comb: got %h expected ff", m_comb_b);
        end
        rst_n_b = 1'b1;
        tick();
        tests_run++;
        if (m_out_b !== 8'hFF || out_valid_b !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL midrst_resume: got m_out=%h valid=%b expected ff/1", m_out_b, out_valid_b);
        end
    endtask

    task automatic test_comb_variant();
        logic vseq [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        logic       prev_valid;
        logic [3:0] exp;
        rst_n_c = 1'b0; in_valid_c = 1'b1; in0_c = 4'h3; in1_c = 4'hC; sel_c = 1'b0;
        tick();
        tests_run++;
        if (out_valid_c !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL comb_reset_valid: got %b expected 0", out_valid_c);
        end
        rst_n_c = 1'b1;
        for (int c = 0; c < 6; c++) begin
            sel_c      = c[0];
            in_valid_c = vseq[c];
            prev_valid = vseq[c];
            #1;
            exp = (c[0]) ? 4'hC : 4'h3;
            tests_run++;
            if (m_out_c !== exp || m_comb_c !== exp) begin
                tests_failed++;
                $display("[TB] FAIL comb_same_cycle step %0d: got m_out=%h m_comb=%h expected %h", c, m_out_c, m_comb_c, exp);
            end
            tick();
            tests_run++;
            if (out_valid_c !== prev_valid) begin
                tests_failed++;
                $display("[TB] FAIL comb_valid_lag step %0d: got %b expected %b", c, out_valid_c, prev_valid);
            end
        end
    endtask

    // Reference: the output register is the last valid selection since reset, valid only for one cycle.
    task automatic test_random();
        logic [7:0] exp_m;
        logic       exp_v;
        logic [7:0] chosen;
        rst_n_b = 1'b0; in_valid_b = 1'b0;
        tick();
        exp_m = 8'h00; exp_v = 1'b0;
        for (int c = 0; c < 300; c++) begin
            rst_n_b    = ($urandom_range(0, 15) != 0);
            in0_b      = 8'($urandom);
            in1_b      = 8'($urandom);
            sel_b      = 1'($urandom);
            in_valid_b = ($urandom_range(0, 3) != 0);
            chosen     = sel_b ? in1_b : in0_b;
            #1;
            tests_run++;
            if (m_comb_b !== chosen) begin
                tests_failed++;
                $display("[TB] FAIL rand_m_comb cycle %0d: got %h expected %h", c, m_comb_b, chosen);
            end
            if (!rst_n_b) begin
                exp_m = 8'h00;
                exp_v = 1'b0;
            end else begin
                exp_v = in_valid_b;
                if (in_valid_b) exp_m = chosen;
            end
            tick();
            tests_run++;
            if (m_out_b !== exp_m || out_valid_b !== exp_v) begin
                tests_failed++;
                $display("[TB] FAIL rand_reg cycle %0d: got m_out=%h valid=%b expected %h/%b", c, m_out_b, out_valid_b, exp_m, exp_v);
            end
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n_a = 1'b0; in0_a = 1'b0; in1_a = 1'b1; sel_a = 1'b1; in_valid_a = 1'b1;
        rst_n_b = 1'b0; in0_b = 8'h00; in1_b = 8'h00; sel_b = 1'b0; in_valid_b = 1'b0;
        rst_n_c = 1'b0; in0_c = 4'h0; in1_c = 4'h0; sel_c = 1'b0; in_valid_c = 1'b0;

        test_reset();
        test_basic_select();
        test_hold();
        test_wide();
        test_mid_reset();
        test_comb_variant();
        test_random();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
